// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per clock: result WIDTH+1 cycles after start (2 for a zero divisor).
// Result is held while start_i stays high; a new operation is accepted only after start_i drops.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     div_q, div_d;
    logic [WIDTH-1:0]     dq_q, dq_d;     // dividend bits shift out of the top, quotient bits fill from below
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     op1_mag, op2_mag;
    logic [WIDTH:0]       trial;
    logic                 ge;
    logic [WIDTH-1:0]     rem_nx, quo_nx, rem_fix, quo_fix;

    always_comb begin
        op1_neg = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg = signed_div_i & opdata2_i[WIDTH-1];
        op1_mag = op1_neg ? -opdata1_i : opdata1_i;
        op2_mag = op2_neg ? -opdata2_i : opdata2_i;

        // Subtraction only happens when trial >= divisor, so the difference fits in WIDTH bits.
        trial   = {rem_q, dq_q[WIDTH-1]};
        ge      = trial >= {1'b0, div_q};
        rem_nx  = ge ? (trial[WIDTH-1:0] - div_q) : trial[WIDTH-1:0];
        quo_nx  = {dq_q[WIDTH-2:0], ge};
        rem_fix = rneg_q ? -rem_nx : rem_nx;
        quo_fix = qneg_q ? -quo_nx : quo_nx;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        dq_d     = dq_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = '0;
        ready_d  = 1'b0;

        case (state_q)
            S_FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d = S_ON;
                        cnt_d   = '0;
                        div_d   = op2_mag;
                        dq_d    = op1_mag;
                        rem_d   = '0;
                        qneg_d  = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        rneg_d  = op1_neg;
                    end
                end
            end
            S_BYZERO: begin
                if (annul_i) begin
                    state_d = S_FREE;
                end else begin
                    state_d = S_END;
                    ready_d = 1'b1;
                end
            end
            S_ON: begin
                if (annul_i) begin
                    state_d = S_FREE;
                    cnt_d   = '0;
                end else begin
                    rem_d = rem_nx;
                    dq_d  = quo_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d  = S_END;
                        ready_d  = 1'b1;
                        result_d = {rem_fix, quo_fix};
                    end
                end
            end
            S_END: begin
                if (annul_i || !start_i) begin
                    state_d = S_FREE;
                end else begin
                    ready_d  = 1'b1;
                    result_d = result_q;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            div_q    <= '0;
            dq_q     <= '0;
            rem_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            dq_q     <= dq_d;
            rem_q    <= rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected results, negedge monitor pops on each ready_o rise.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, remainder takes dividend sign.
    function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv, q, r;
        if (b == 0) return 64'd0;
        if (!sg) return {a % b, a / b};
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        q   = sa / sbv;
        r   = sa % sbv;
        return {r[31:0], q[31:0]};
    endfunction

    always @(negedge clk) begin
        exp_t x;
        if (ready_o && !prev_rdy) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 65'd1, 65'd0);
            end else begin
                x = sb_q.pop_front();
                check("result", {1'b0, result_o}, {1'b0, x.res});
                check("latency", 65'(cyc), 65'(x.cyc));
            end
        end
        prev_rdy <= ready_o;
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t x;
        x.res = model(sg, a, b);
        x.cyc = cyc + ((b == 0) ? 2 : 33);
        sb_q.push_back(x);
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(negedge clk);
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom);
        for (int i = 0; i < 60 && !ready_o; i++) @(negedge clk);
        if (!ready_o) begin
            check("ready_timeout", 65'd0, 65'd1);
            sb_q.delete();
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_stable", {ready_o, result_o}, {1'b1, x.res});
            end
        end
        start_i = 1'b0;
        @(negedge clk);
        check("drop_clears", {ready_o, result_o}, 65'd0);
    endtask

    function automatic logic [31:0] rand_divisor();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 9));
            2:       return 32'hFFFF_FFFF;
            3:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit          seen;
        logic [31:0] a, b;
        exp_t        x;

        #3;
        check("reset_async", {ready_o, result_o}, 65'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_idle", {ready_o, result_o}, 65'd0);

        run_op(1'b0, 32'd100, 32'd7, 2);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1);
        run_op(1'b0, 32'd5, 32'd0, 2);
        run_op(1'b1, 32'd5, 32'd0, 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Abort in the middle of the iteration phase.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen = 1'b1;
        end
        check("annul_no_ready", {64'd0, seen}, 65'd0);
        run_op(1'b0, 32'd9, 32'd3, 0);

        // Reset while iterating.
        opdata1_i = 32'd77;
        opdata2_i = 32'd4;
        start_i   = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("reset_mid_on", {ready_o, result_o}, 65'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(1'b0, 32'd12, 32'd5, 1);

        // Reset while a result is being held.
        x.res = model(1'b1, 32'hFFFF_FC18, 32'd7);
        x.cyc = cyc + 33;
        sb_q.push_back(x);
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFF_FC18;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        for (int i = 0; i < 60 && !ready_o; i++) @(negedge clk);
        check("end_reached", {64'd0, ready_o}, 65'd1);
        #2 rst = 1'b0;
        #1 check("reset_in_end", {ready_o, result_o}, 65'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb_q.delete();

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 50));
            b = rand_divisor();
            run_op(1'($urandom), a, b, $urandom_range(0, 2));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 65'(sb_q.size()), 65'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
